// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package forwarding_hazard_unit_pkg;

  localparam int unsigned RegAddrWDefault = 3;
  // Entries carry rd at a fixed width so one packed type serves every REG_ADDR_W <= this.
  localparam int unsigned MaxRegAddrW     = 8;
  // Select value meaning "use the register-file value".
  localparam int unsigned FWD_NONE        = 0;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic                   is_load;
    logic [MaxRegAddrW-1:0] rd;
  } entry_t;

  // A live writer will really update rd; register 0 is ignored when it is hard-wired.
  function automatic logic is_live_writer(entry_t e, logic has_zero_reg);
    return e.valid & e.we & ~(has_zero_reg & (e.rd == '0));
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_priority_match.sv
// Priority match of one EX source register against the downstream result stages.
module forwarding_hazard_unit_fwd_priority_match
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = RegAddrWDefault,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned HAS_ZERO_REG = 0,
  parameter int unsigned SEL_W        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  entry_t [FWD_DEPTH-1:0] fwd_i,  // index 0 is stage 1
  output logic [SEL_W-1:0]      sel_o,
  output logic                  load_hit_o
);

  // Walk oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    sel_o      = SEL_W'(FWD_NONE);
    load_hit_o = 1'b0;
    for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
      if (ex_valid_i && is_live_writer(fwd_i[k], HAS_ZERO_REG != 0) &&
          (fwd_i[k].rd == MaxRegAddrW'(rs_i))) begin
        sel_o      = SEL_W'(k + 1);
        load_hit_o = fwd_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow pipeline tracking in-flight writes: forwarding selects, load-use stall, stall counter.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = RegAddrWDefault,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned HAS_ZERO_REG = 0,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SEL_W        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_hold,
  input  logic                          i_flush,
  input  logic                          i_id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0]         i_id_rd,
  input  logic                          i_id_we,
  input  logic                          i_id_is_load,
  output logic                          o_stall,
  output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
  output logic [CNT_W-1:0]              o_stall_count
);

  entry_t                          ex_q, ex_d;
  logic [NUM_SRC*REG_ADDR_W-1:0]   ex_rs_q, ex_rs_d;
  entry_t [FWD_DEPTH-1:0]          fwd_q, fwd_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            rs_hit;
  logic [NUM_SRC-1:0]              load_hit;

  // Does any decode source name the register the EX instruction writes?
  always_comb begin
    rs_hit = 1'b0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (ex_q.rd == MaxRegAddrW'(i_id_rs[s*REG_ADDR_W +: REG_ADDR_W])) begin
        rs_hit = 1'b1;
      end
    end
  end

  // Flush kills the consumer, so it also cancels the stall.
  assign o_stall = ~i_flush & i_id_valid & is_live_writer(ex_q, HAS_ZERO_REG != 0) &
                   ex_q.is_load & rs_hit;

  assign o_stall_count = cnt_q;

  // Advance the shadow pipeline and counter unless the whole pipe is held.
  always_comb begin
    ex_d    = ex_q;
    ex_rs_d = ex_rs_q;
    fwd_d   = fwd_q;
    cnt_d   = cnt_q;
    if (!i_hold) begin
      fwd_d[0] = ex_q;
      for (int k = 1; k < int'(FWD_DEPTH); k++) begin
        fwd_d[k] = fwd_q[k-1];
      end
      ex_d    = '0;
      ex_rs_d = i_id_rs;
      if (i_id_valid && !o_stall && !i_flush) begin
        ex_d.valid   = 1'b1;
        ex_d.we      = i_id_we;
        ex_d.is_load = i_id_is_load;
        ex_d.rd      = MaxRegAddrW'(i_id_rd);
      end
      if (o_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous reset to an empty pipeline.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q    <= '0;
      ex_rs_q <= '0;
      fwd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      ex_rs_q <= ex_rs_d;
      fwd_q   <= fwd_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    forwarding_hazard_unit_fwd_priority_match #(
      .REG_ADDR_W  (REG_ADDR_W),
      .FWD_DEPTH   (FWD_DEPTH),
      .HAS_ZERO_REG(HAS_ZERO_REG),
      .SEL_W       (SEL_W)
    ) u_match (
      .ex_valid_i(ex_q.valid),
      .rs_i      (ex_rs_q[s*REG_ADDR_W +: REG_ADDR_W]),
      .fwd_i     (fwd_q),
      .sel_o     (o_fwd_sel[s*SEL_W +: SEL_W]),
      .load_hit_o(load_hit[s])
    );

    // The load-use stall must keep a load from ever being the stage-1 source.
    assert property (@(posedge i_clk) disable iff (i_reset)
      !((o_fwd_sel[s*SEL_W +: SEL_W] == SEL_W'(1)) && load_hit[s]));
  end

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Parametrised successor to the single-stage forwarding selector: it tracks in-flight register writes across a configurable number of downstream stages, produces a priority-encoded forwarding select per ALU source, and detects load-use hazards. It sits alongside the decode/execute boundary, snooping decode-stage register fields and following each instruction through EX and the downstream stages with its own shadow pipeline. It also drives the decode stall and keeps a saturating stall-cycle counter.

## Interface
- REG_ADDR_W, 3, register address width
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, downstream result stages tracked (1 = EX/MEM, 2 = MEM/WB, ...); min 1
- HAS_ZERO_REG, 0, if 1, register 0 is hard-wired and never forwarded or stalled on
- CNT_W, 16, stall counter width
- SEL_W, $clog2(FWD_DEPTH+1), derived; forwarding select width
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_hold  in  1  global pipeline freeze (e.g. memory busy)
- i_flush  in  1  kill the instruction in decode (branch taken)
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_rs  in  NUM_SRC*REG_ADDR_W  decode source registers; src s at [s*REG_ADDR_W +: REG_ADDR_W]
- i_id_rd  in  REG_ADDR_W  decode destination register
- i_id_we  in  1  decode instruction writes back
- i_id_is_load  in  1  decode instruction is a memory load
- o_stall  out  1  hold decode/fetch, insert a bubble into EX
- o_fwd_sel  out  NUM_SRC*SEL_W  per-source select for the instruction in EX; 0 = register-file value, k = result of stage k
- o_stall_count  out  CNT_W  saturating count of stall cycles

Clock is i_clk; reset is i_reset, asynchronous and active-high.

## Operation
- Entry: {valid, we, is_load, rd}; the EX entry additionally holds rs[NUM_SRC].
- A live writer is valid & we, excluding rd==0 when HAS_ZERO_REG=1.
- Shadow pipeline: ex entry, then fwd[1..FWD_DEPTH].
- Per clock with i_hold=0:
  - fwd[k+1] <= fwd[k]; fwd[1] <= ex.
  - ex <= decode fields if i_id_valid & ~o_stall & ~i_flush, else bubble (valid=0).
- i_hold=1: all state frozen, counter frozen; outputs still evaluated from the frozen state.
- o_fwd_sel[s] is combinational from registered state:
  - Find the smallest k with fwd[k] a live writer and fwd[k].rd == ex.rs[s].
  - Result is k; 0 if there is no match or ex.valid=0.
  - The youngest producer always wins.
- o_stall is combinational: ~i_flush & i_id_valid & ex is a live writer & ex.is_load & (ex.rd equals any i_id_rs[s]).
- HAS_ZERO_REG=1 suppresses matches on register 0 for both forwarding and stall.
- Invariant: because of the stall, a load entry never becomes the forwarding source at fwd[1] for a dependent EX instruction.
- o_stall_count increments when o_stall & ~i_hold, and saturates at 2^CNT_W-1.

## Timing
- Reset values: all entries invalid, o_fwd_sel=0, o_stall=0, o_stall_count=0.
- Reset takes effect immediately and asynchronously, including mid-stall or mid-hold; the first post-reset edge captures normally.
- Forwarding latency: a producer captured into ex at edge N is visible as stage 1 at edge N+1 and stage k at edge N+k. It drops out after stage FWD_DEPTH.
- Load-use: consumer stalls exactly 1 cycle (absent i_hold). The load then moves to fwd[1], the consumer enters EX, and it sees select 2 when FWD_DEPTH>=2.
- Simultaneous flush and hazard: flush wins. o_stall=0, a bubble enters EX, and the counter does not increment.
- Simultaneous hold and hazard: o_stall=1 is held, no increment, no state change.
- Same rd in several stages: the smallest k is chosen. A non-writing (we=0) younger entry does not shadow an older writer.

## Structure
- Shared package (pipeline pkg): entry typedef, REG_ADDR_W default, select encoding constants (FWD_NONE=0).
- One natural sub-module: fwd_priority_match. It is purely combinational and is instantiated NUM_SRC times. It takes one rs plus the FWD_DEPTH entries and returns the SEL_W select.
- Shadow pipeline, stall detect, and counter live in the top module.

## Test plan
- Reset mid-stream: a load to r3 sits in ex, consumer in decode, o_stall=1; assert i_reset → o_stall=0, o_fwd_sel=0, count=0 immediately.
- Back-to-back ALU writes: ADD r2 then SUB r4,r2,r2 → next cycle o_fwd_sel for both sources is 1; one cycle later with no further writer to r2, it is 2.
- Priority: writes to r5 in consecutive cycles, then a consumer of r5 → select 1, not 2. Repeat with the younger instruction having we=0 → select 2.
- Load-use: LDD r1 then ADD r6,r1,r0 → o_stall=1 for exactly one cycle; the consumer then in EX has select 2 on src0 and 0 on src1; count=1.
- Hold and flush: load-use with i_hold=1 for 3 cycles → stall stays 1, count unchanged; hazard with i_flush=1 → o_stall=0, ex becomes a bubble.
- Parameter sweep: FWD_DEPTH=3, HAS_ZERO_REG=1, CNT_W=2.
  - A writer of r0 is never forwarded or stalled on.
  - A writer of r7 reaches select 3 after three edges.
  - Four stalls leave the count saturated at 3.
